// File: rtl/w_writeback_grf_pkg.sv
// Shared select codes for the writeback stage: load-extension mode, destination
// register source and write-data source.
package w_writeback_grf_pkg;

  localparam logic [2:0] RD_LW  = 3'd0;
  localparam logic [2:0] RD_LB  = 3'd1;
  localparam logic [2:0] RD_LBU = 3'd2;
  localparam logic [2:0] RD_LH  = 3'd3;
  localparam logic [2:0] RD_LHU = 3'd4;

  localparam logic [2:0] A3_RT = 3'd0;
  localparam logic [2:0] A3_RD = 3'd1;
  localparam logic [2:0] A3_RA = 3'd2;

  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_DM  = 3'd1;
  localparam logic [2:0] WD_PC8 = 3'd2;
  localparam logic [2:0] WD_HI  = 3'd3;
  localparam logic [2:0] WD_LO  = 3'd4;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/w_writeback_grf_load_ext.sv
// Combinational load extension: picks the byte/halfword addressed by the low
// address bits out of the aligned memory word and sign- or zero-extends it.
module w_writeback_grf_load_ext
  import w_writeback_grf_pkg::*;
(
  input  logic [2:0]  readsel,
  input  logic [1:0]  offset,
  input  logic [31:0] dm_word,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dm_word[{offset, 3'b000} +: 8];
    // A misaligned halfword ignores offset[0] and takes the half chosen by offset[1].
    half_sel = dm_word[{offset[1], 4'b0000} +: 16];
    case (readsel)
      RD_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      RD_LBU:  ext_data = {24'd0, byte_sel};
      RD_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      RD_LHU:  ext_data = {16'd0, half_sel};
      default: ext_data = dm_word;
    endcase
  end

endmodule

// File: rtl/w_writeback_grf.sv
// Writeback stage plus general register file: selects A3/WD, commits into the GRF,
// serves two bypassed read ports, exports the W forwarding pair and counts retirements.
module w_writeback_grf
  import w_writeback_grf_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned PC_OFFSET   = 8,
  parameter logic [31:0] INSTRET_RST = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                W_IF,
  input  logic [DATA_W-1:0]          W_PCadd8,
  input  logic [DATA_W-1:0]          W_ALUout,
  input  logic [DATA_W-1:0]          W_DMout,
  input  logic [DATA_W-1:0]          W_HI,
  input  logic [DATA_W-1:0]          W_LO,
  input  logic [2:0]                 W_Readsel,
  input  logic [2:0]                 W_A3sel,
  input  logic [2:0]                 W_WDsel,
  input  logic                       W_GRFEn,
  input  logic [$clog2(REG_NUM)-1:0] D_rs_addr,
  input  logic [$clog2(REG_NUM)-1:0] D_rt_addr,
  output logic [DATA_W-1:0]          D_rs_data,
  output logic [DATA_W-1:0]          D_rt_data,
  output logic [$clog2(REG_NUM)-1:0] W_fwd_addr,
  output logic [DATA_W-1:0]          W_fwd_data,
  output logic [DATA_W-1:0]          wb_pc,
  output logic [31:0]                instret
);

  localparam int unsigned ADDR_W = $clog2(REG_NUM);

  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] ext_data;
  logic              we;

  logic [DATA_W-1:0] grf_q [REG_NUM];
  logic [31:0]       instret_q;

  w_writeback_grf_load_ext u_load_ext (
    .readsel  (W_Readsel),
    .offset   (W_ALUout[1:0]),
    .dm_word  (W_DMout),
    .ext_data (ext_data)
  );

  always_comb begin
    case (W_A3sel)
      A3_RT:   a3 = W_IF[20:16];
      A3_RD:   a3 = W_IF[15:11];
      A3_RA:   a3 = REG_RA;
      default: a3 = '0;
    endcase
  end

  always_comb begin
    case (W_WDsel)
      WD_ALU:  wd = W_ALUout;
      WD_DM:   wd = ext_data;
      WD_PC8:  wd = W_PCadd8;
      WD_HI:   wd = W_HI;
      WD_LO:   wd = W_LO;
      default: wd = '0;
    endcase
  end

  // Gating with reset keeps the bypass and forwarding quiet while the file is held cleared.
  assign we = reset && W_GRFEn && (a3 != '0);

  always_comb begin
    if (D_rs_addr == '0) begin
      D_rs_data = '0;
    end else if (we && (D_rs_addr == a3)) begin
      D_rs_data = wd;
    end else begin
      D_rs_data = grf_q[D_rs_addr];
    end

    if (D_rt_addr == '0) begin
      D_rt_data = '0;
    end else if (we && (D_rt_addr == a3)) begin
      D_rt_data = wd;
    end else begin
      D_rt_data = grf_q[D_rt_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        grf_q[i] <= '0;
      end
    end else if (we) begin
      grf_q[a3] <= wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= INSTRET_RST;
    end else if (W_IF != 32'd0) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign W_fwd_addr = we ? a3 : '0;
  assign W_fwd_data = wd;
  assign wb_pc      = W_PCadd8 - DATA_W'(PC_OFFSET);
  assign instret    = instret_q;

endmodule

// File: tb/tb_w_writeback_grf.sv
// Self-checking bench for w_writeback_grf: directed literal cases followed by
// randomized traffic compared every cycle against an array-based register-file model.
module tb_w_writeback_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_IF, W_PCadd8, W_ALUout, W_DMout, W_HI, W_LO;
  logic [2:0]  W_Readsel, W_A3sel, W_WDsel;
  logic        W_GRFEn;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_fwd_data, wb_pc, instret;
  logic [4:0]  W_fwd_addr;
  // second instance whose counter resets to all-ones, used for the wrap case
  logic [31:0] rs2, rt2, fwd_data2, wb_pc2, instret2;
  logic [4:0]  fwd_addr2;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  w_writeback_grf dut (
    .clk(clk), .reset(reset), .W_IF(W_IF), .W_PCadd8(W_PCadd8), .W_ALUout(W_ALUout),
    .W_DMout(W_DMout), .W_HI(W_HI), .W_LO(W_LO), .W_Readsel(W_Readsel),
    .W_A3sel(W_A3sel), .W_WDsel(W_WDsel), .W_GRFEn(W_GRFEn), .D_rs_addr(D_rs_addr),
    .D_rt_addr(D_rt_addr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .W_fwd_addr(W_fwd_addr), .W_fwd_data(W_fwd_data), .wb_pc(wb_pc), .instret(instret)
  );

  w_writeback_grf #(.INSTRET_RST(32'hFFFF_FFFF)) dut2 (
    .clk(clk), .reset(reset), .W_IF(W_IF), .W_PCadd8(W_PCadd8), .W_ALUout(W_ALUout),
    .W_DMout(W_DMout), .W_HI(W_HI), .W_LO(W_LO), .W_Readsel(W_Readsel),
    .W_A3sel(W_A3sel), .W_WDsel(W_WDsel), .W_GRFEn(W_GRFEn), .D_rs_addr(D_rs_addr),
    .D_rt_addr(D_rt_addr), .D_rs_data(rs2), .D_rt_data(rt2),
    .W_fwd_addr(fwd_addr2), .W_fwd_data(fwd_data2), .wb_pc(wb_pc2), .instret(instret2)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_grf [32];
  logic [31:0] m_instret;

  function automatic logic [31:0] m_ext(logic [2:0] sel, logic [31:0] alu, logic [31:0] dm);
    logic [31:0] b, h;
    b = (dm >> (alu[1:0] * 8)) & 32'h0000_00FF;
    h = (dm >> (alu[1] * 16)) & 32'h0000_FFFF;
    case (sel)
      3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return dm;
    endcase
  endfunction

  function automatic logic [4:0] m_a3();
    case (W_A3sel)
      3'd0:    return W_IF[20:16];
      3'd1:    return W_IF[15:11];
      3'd2:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_wd();
    case (W_WDsel)
      3'd0:    return W_ALUout;
      3'd1:    return m_ext(W_Readsel, W_ALUout, W_DMout);
      3'd2:    return W_PCadd8;
      3'd3:    return W_HI;
      3'd4:    return W_LO;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_we();
    return (reset === 1'b1) && W_GRFEn && (m_a3() != 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (m_we() && addr == m_a3()) return m_wd();
    return m_grf[addr];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (m_grf[i]) m_grf[i] <= 32'd0;
      m_instret <= 32'd0;
    end else begin
      if (m_we()) m_grf[m_a3()] <= m_wd();
      if (W_IF != 32'd0) m_instret <= m_instret + 32'd1;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rs_data", D_rs_data, m_rd(D_rs_addr));
      check("rt_data", D_rt_data, m_rd(D_rt_addr));
      check("fwd_addr", {27'd0, W_fwd_addr}, m_we() ? {27'd0, m_a3()} : 32'd0);
      check("fwd_data", W_fwd_data, m_wd());
      check("wb_pc", wb_pc, W_PCadd8 - 32'd8);
      check("instret", instret, m_instret);
      check("rs_data2", rs2, m_rd(D_rs_addr));
      check("rt_data2", rt2, m_rd(D_rt_addr));
      check("fwd_addr2", {27'd0, fwd_addr2}, m_we() ? {27'd0, m_a3()} : 32'd0);
      check("fwd_data2", fwd_data2, m_wd());
      check("wb_pc2", wb_pc2, W_PCadd8 - 32'd8);
      check("instret2", instret2, m_instret - 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    W_IF = 0; W_PCadd8 = 0; W_ALUout = 0; W_DMout = 0; W_HI = 0; W_LO = 0;
    W_Readsel = 0; W_A3sel = 0; W_WDsel = 0; W_GRFEn = 0; D_rs_addr = 0; D_rt_addr = 0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    D_rs_addr = 5'd5;
    tick(); tick();
    check("rst_rs", D_rs_data, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_instret2", instret2, 32'hFFFF_FFFF);
    reset = 1'b1;

    // load extension
    W_DMout = 32'h80FF_7F01; W_WDsel = 3'd1;
    W_ALUout = 32'd1; W_Readsel = 3'd1; #1 check("lb_off1", W_fwd_data, 32'h0000_007F);
    W_ALUout = 32'd3;                    #1 check("lb_off3", W_fwd_data, 32'hFFFF_FF80);
    W_Readsel = 3'd2;                    #1 check("lbu_off3", W_fwd_data, 32'h0000_0080);
    W_ALUout = 32'd2; W_Readsel = 3'd4;  #1 check("lhu_off2", W_fwd_data, 32'h0000_80FF);
    W_ALUout = 32'd3; W_Readsel = 3'd3;  #1 check("lh_misal", W_fwd_data, 32'hFFFF_80FF);
    W_ALUout = 32'd1;                    #1 check("lh_off1", W_fwd_data, 32'h0000_7F01);
    W_Readsel = 3'd0;                    #1 check("lw", W_fwd_data, 32'h80FF_7F01);

    // A3 = $31, WD = PC+8
    idle();
    W_A3sel = 3'd2; W_WDsel = 3'd2; W_PCadd8 = 32'h0000_3008; W_GRFEn = 1'b1;
    #1;
    check("wb_pc", wb_pc, 32'h0000_3000);
    check("ra_fwd_addr", {27'd0, W_fwd_addr}, 32'd31);
    tick();
    W_GRFEn = 1'b0; D_rs_addr = 5'd31;
    #1 check("ra_commit", D_rs_data, 32'h0000_3008);

    // write to $0
    idle();
    W_ALUout = 32'h0000_DEAD; W_GRFEn = 1'b1;
    #1;
    check("r0_fwd_addr", {27'd0, W_fwd_addr}, 32'd0);
    check("r0_read", D_rs_data, 32'd0);
    tick();
    check("r0_after", D_rs_data, 32'd0);

    // disabled write leaves $7 alone
    W_IF = 32'h0007_0000; W_ALUout = 32'h77; tick();
    W_ALUout = 32'h1111; W_GRFEn = 1'b0; D_rs_addr = 5'd7;
    #1 check("r7_nobypass", D_rs_data, 32'h77);
    tick();
    check("r7_kept", D_rs_data, 32'h77);

    // same-cycle bypass on both ports
    W_IF = 32'h0009_0000; W_ALUout = 32'h0000_CAFE; W_GRFEn = 1'b1;
    D_rs_addr = 5'd9; D_rt_addr = 5'd9;
    #1;
    check("byp_rs", D_rs_data, 32'h0000_CAFE);
    check("byp_rt", D_rt_data, 32'h0000_CAFE);
    tick();
    W_GRFEn = 1'b0; W_ALUout = 32'd0;
    #1;
    check("byp_rs_after", D_rs_data, 32'h0000_CAFE);
    check("byp_rt_after", D_rt_data, 32'h0000_CAFE);

    // reset mid-cycle drops the pending write
    W_IF = 32'h0005_0000; W_ALUout = 32'h1234; W_GRFEn = 1'b1; D_rs_addr = 5'd5;
    tick();
    W_ALUout = 32'h5555;
    #1 check("r5_bypass", D_rs_data, 32'h5555);
    #2 reset = 1'b0;
    #1;
    check("midrst_rs", D_rs_data, 32'd0);
    check("midrst_instret", instret, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    W_IF = 32'd0; W_GRFEn = 1'b0;
    #1 check("midrst_discard", D_rs_data, 32'd0);

    // retirement counter: 3 instr, 1 bubble, 2 instr
    W_IF = 32'h0000_0001;
    tick();
    check("cnt_1", instret, 32'd1);
    check("cnt_wrap", instret2, 32'd0);
    tick(); tick();
    W_IF = 32'd0; tick();
    check("cnt_bubble", instret, 32'd3);
    W_IF = 32'h0000_0001; tick(); tick();
    check("cnt_5", instret, 32'd5);

    // randomized traffic against the model
    W_IF = 32'd0;
    @(negedge clk);
    chk_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(199) == 0) reset = 1'b0;
      W_IF      = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      W_PCadd8  = $urandom;
      W_ALUout  = $urandom;
      W_DMout   = $urandom;
      W_HI      = $urandom;
      W_LO      = $urandom;
      W_Readsel = 3'($urandom_range(7));
      W_A3sel   = 3'($urandom_range(4));
      W_WDsel   = 3'($urandom_range(6));
      W_GRFEn   = ($urandom_range(3) != 0);
      D_rs_addr = ($urandom_range(1) == 0) ? W_IF[20:16] : 5'($urandom);
      D_rt_addr = ($urandom_range(2) == 0) ? W_IF[15:11] : 5'($urandom);
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
